hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sits beside the decode-stage instruction controller and drives the pipeline-register enables and flushes: load-use stalls, branch/jump operand stalls, control-transfer flushes, and data-memory wait freezes. A small FSM tracks outstanding data-memory accesses and times out to a sticky error state.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive cycles a MEM-stage access may wait for `dmem_ready` before the error state is entered (1..255).
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_rs, id_rt  in  5 each  source register numbers of the ID-stage instruction.
- id_use_rs, id_use_rt  in  1 each  the ID instruction reads rs / rt.
- id_branch  in  1  ID instruction is beq/bne/blez/bgtz/bltz; compares in ID.
- id_branch_taken  in  1  ID comparator result; valid only when `id_branch`=1.
- id_jump, id_jump_src  in  1 each  ID is j/jal/jr/jalr; `id_jump_src`=1 means the target comes from rs (jr/jalr).
- ex_mem_read, ex_reg_write  in  1 each  EX-stage instruction is lw / writes a register.
- ex_wr_reg  in  5  EX-stage destination register.
- mem_mem_read  in  1  MEM-stage instruction is lw.
- mem_wr_reg  in  5  MEM-stage destination register.
- mem_access  in  1  MEM stage holds lw or sw.
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  pipeline-register write enables.
- ifid_flush, idex_flush  out  1 each  load a bubble into IF/ID / ID/EX.
- memwb_bubble  out  1  MEM/WB captures a bubble.
- err  out  1  sticky memory-timeout error.
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

## Operation
- Match rule: a hazard on register r exists only if r≠0 and the relevant `id_use_*` is set.
- Load-use stall (LU): `ex_mem_read` and `ex_wr_reg` matches rs or rt.
- Branch-operand stall (BR): ID is a branch or jr/jalr, and either `ex_reg_write` with `ex_wr_reg` match, or `mem_mem_read` with `mem_wr_reg` match.
- Freeze (FZ): state MEM_WAIT or ERROR, or (state RUN and `mem_access` and !`dmem_ready`).
- Priority FZ > (LU|BR) > flush.
- FZ: all *_we=0, `ifid_flush`=`idex_flush`=0, `memwb_bubble`=1.
- LU|BR: `pc_we`=`ifid_we`=0, `idex_flush`=1, `idex_we`=`exmem_we`=1, `ifid_flush`=0.
- Flush (no FZ, no stall): `id_jump`, or `id_branch`&`id_branch_taken` -> `ifid_flush`=1; the instruction fetched after the control transfer is discarded (no delay slot).
- Otherwise all *_we=1 and all flush/bubble outputs=0.
- FSM states:
  - RUN -> MEM_WAIT when `mem_access`&!`dmem_ready`; wait_cnt<=1.
  - MEM_WAIT: if `dmem_ready` -> RUN; else if wait_cnt==MEM_TIMEOUT -> ERROR; else wait_cnt+1.
  - ERROR: holds until reset; `err`=1.
- wait_cnt is 8 bits and never wraps; it is cleared on entry to RUN.

## Timing
- All hazard outputs are combinational from the current state and inputs; zero-cycle decision latency.
- Reset cycle, and the state after reset: state=RUN, wait_cnt=0, `err`=0, counters=0. While `reset`=1, all *_we=0, flushes=0, `memwb_bubble`=1.
- LU lasts exactly 1 cycle. BR lasts 1 cycle for an EX producer, and 2 cycles for a lw producer: EX, then MEM.
- A `dmem_ready` pulse in the same cycle as `mem_access` gives no freeze.
- A `dmem_ready` pulse in the cycle wait_cnt==MEM_TIMEOUT returns to RUN, not ERROR.
- A taken branch that coincides with FZ or a stall produces no flush that cycle. The flush is produced when the branch is finally released.
- Reset during MEM_WAIT or ERROR returns to RUN on the next edge.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - `stall_cnt` increments on each cycle with FZ or LU or BR.
  - `flush_cnt` increments on each cycle with `ifid_flush`=1.
  - Both counters saturate at 0xFFFFFFFF and are cleared by reset.
- HAZARD_PERF_CNT_EN undefined: both counter outputs are tied to 0 and no counter flops are built.

## Structure
- A shared package `hazard_pkg` holds the FSM state encoding (RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10) and the register-zero constant.
- One sub-module, `hazard_perf_cnt`, holds the saturating counter and is instantiated twice under the macro.

## Test plan
- lw $8 in EX, ID `add` reads rs=8 -> 1 cycle with `pc_we`=0, `ifid_we`=0, `idex_flush`=1; the next cycle is normal.
- `beq` rs=9 in ID with lw $9 in EX -> 2 stall cycles, then `ifid_flush`=1 if `id_branch_taken`=1.
- `jr` rs=0 with `ex_reg_write`, `ex_wr_reg`=0 -> no stall; `ifid_flush`=1 immediately.
- `mem_access`=1, `dmem_ready` low for 3 cycles -> freeze in 4 cycles total (RUN + 3 MEM_WAIT); RUN resumes on the `dmem_ready` cycle; `err`=0.
- MEM_TIMEOUT=4, `dmem_ready` held low -> ERROR after wait_cnt=4; `err`=1 sticky; reset clears it.
- With HAZARD_PERF_CNT_EN, run the previous scenarios -> `stall_cnt`/`flush_cnt` equal the counted cycles. Preloading 0xFFFFFFFE saturates the counters at 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : shared FSM encoding and register-match helper for hazard_ctrl
// Rev 1.0    : initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src,
                                     input logic       use_src,
                                     input logic [4:0] dst);
    return use_src && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : pipeline-status inputs and pipeline-control outputs
// Rev 1.0        : initial release
// ============================================================================
interface hazard_ctrl_if;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_branch;
  logic        id_branch_taken;
  logic        id_jump;
  logic        id_jump_src;
  logic        ex_mem_read;
  logic        ex_reg_write;
  logic [4:0]  ex_wr_reg;
  logic        mem_mem_read;
  logic [4:0]  mem_wr_reg;
  logic        mem_access;
  logic        dmem_ready;

  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_bubble;
  logic        err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_branch_taken,
           id_jump, id_jump_src, ex_mem_read, ex_reg_write, ex_wr_reg,
           mem_mem_read, mem_wr_reg, mem_access, dmem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
           memwb_bubble, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_branch_taken,
           id_jump, id_jump_src, ex_mem_read, ex_reg_write, ex_wr_reg,
           mem_mem_read, mem_wr_reg, mem_access, dmem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
           memwb_bubble, err, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// hazard_perf_cnt : 32-bit saturating event counter, cleared by reset
// Rev 1.0         : initial release
// ============================================================================
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : 5-stage MIPS stall/flush/freeze controller with dmem timeout
//               Perf counters built only when HAZARD_PERF_CNT_EN is defined.
// Rev 1.0     : initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_e     state_q;
  logic [7:0] wait_cnt_q;
  logic       err_q;

  logic ex_match;
  logic mem_match;
  logic lu_stall;
  logic br_stall;
  logic any_stall;
  logic freeze;
  logic xfer;

  assign ex_match  = reg_match(bus.id_rs, bus.id_use_rs, bus.ex_wr_reg)
                   | reg_match(bus.id_rt, bus.id_use_rt, bus.ex_wr_reg);
  assign mem_match = reg_match(bus.id_rs, bus.id_use_rs, bus.mem_wr_reg)
                   | reg_match(bus.id_rt, bus.id_use_rt, bus.mem_wr_reg);

  assign lu_stall  = bus.ex_mem_read && ex_match;
  // ID-stage compares need the operand itself, so a lw still in MEM also blocks.
  assign br_stall  = (bus.id_branch || (bus.id_jump && bus.id_jump_src))
                  && ((bus.ex_reg_write && ex_match) || (bus.mem_mem_read && mem_match));
  assign any_stall = lu_stall || br_stall;
  assign freeze    = (state_q != RUN) || (bus.mem_access && !bus.dmem_ready);
  assign xfer      = bus.id_jump || (bus.id_branch && bus.id_branch_taken);

  always_comb begin
    bus.pc_we        = 1'b1;
    bus.ifid_we      = 1'b1;
    bus.idex_we      = 1'b1;
    bus.exmem_we     = 1'b1;
    bus.ifid_flush   = xfer;
    bus.idex_flush   = 1'b0;
    bus.memwb_bubble = 1'b0;
    if (reset || freeze) begin
      bus.pc_we        = 1'b0;
      bus.ifid_we      = 1'b0;
      bus.idex_we      = 1'b0;
      bus.exmem_we     = 1'b0;
      bus.ifid_flush   = 1'b0;
      bus.memwb_bubble = 1'b1;
    end else if (any_stall) begin
      bus.pc_we      = 1'b0;
      bus.ifid_we    = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.mem_access && !bus.dmem_ready) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end else begin
            wait_cnt_q <= '0;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == TIMEOUT_LIM) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ERROR: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= ERROR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_evt;
  assign stall_evt = freeze || any_stall;

  hazard_perf_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stall_evt),
    .cnt_o (bus.stall_cnt)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (bus.ifid_flush),
    .cnt_o (bus.flush_cnt)
  );
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule
`default_nettype wire
